// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - Wishbone-classic read bus between the fetch unit and instruction memory
//
// Signals:
//   wb_cyc_o, wb_stb_o  bus cycle / strobe (master -> slave)
//   wb_we_o, wb_sel_o   write enable (always 0) / byte selects (always all ones)
//   wb_adr_o            request address
//   wb_dat_i, wb_ack_i  read data / acknowledge (slave -> master)
// Modports: master (fetch unit side), slave (memory side).
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [3:0]            wb_sel_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RISC-V instruction fetch stage: PC, Wishbone read master, IF/ID register
//
// Optional feature macro: IF_PERF_CNT_EN (adds fetch_count / redirect_count outputs).
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   stall, flush        hazard-unit hold / squash of IF/ID
//   use_branch          one-cycle redirect pulse, target on branch_out
//   wb                  Wishbone-classic read master (if_fetch_unit_if.master)
//   inst_out, pc_out    IF/ID instruction and its PC
//   inst_valid          IF/ID valid
//   fetch_count         (IF_PERF_CNT_EN) acks accepted into IF/ID or the hold buffer
//   redirect_count      (IF_PERF_CNT_EN) cycles with use_branch high
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  use_branch,
    input  logic [ADDR_WIDTH-1:0] branch_out,
    if_fetch_unit_if.master       wb,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  inst_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           redirect_count
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP, S_HOLD} state_t;

    state_t                state;
    logic                  bus_active;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] req_adr;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_buf;

    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] req_next;
    logic                  ack;
    logic                  deliver_bus;
    logic                  deliver_hold;

    assign target   = {branch_out[ADDR_WIDTH-1:2], 2'b00};
    assign req_next = req_adr + ADDR_WIDTH'(4);
    // Acks outside an active cycle (e.g. left over across a reset) are not ours.
    assign ack      = bus_active & wb.wb_ack_i;

    assign deliver_bus  = (state == S_BUSY) && ack && !use_branch && !stall;
    assign deliver_hold = (state == S_HOLD) && !stall && !use_branch;

    // bus_active mirrors state in {S_BUSY, S_DROP} as a register of its own.
    assign wb.wb_cyc_o = bus_active;
    assign wb.wb_stb_o = bus_active;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = 4'b1111;
    assign wb.wb_adr_o = req_adr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            bus_active <= 1'b0;
            pc_reg     <= PC_ADDR;
            req_adr    <= PC_ADDR;
            hold_pc    <= PC_ADDR;
            hold_buf   <= NOP;
            inst_out   <= NOP;
            pc_out     <= PC_ADDR;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (use_branch) begin
                        pc_reg  <= target;
                        req_adr <= target;
                    end else begin
                        req_adr <= pc_reg;
                    end
                    state      <= S_BUSY;
                    bus_active <= 1'b1;
                end
                S_BUSY: begin
                    if (use_branch) begin
                        pc_reg <= target;
                        if (ack) begin
                            state      <= S_IDLE;
                            bus_active <= 1'b0;
                        end else begin
                            // Request must stay on the bus until it is acked.
                            state <= S_DROP;
                        end
                    end else if (ack) begin
                        pc_reg <= req_next;
                        if (stall) begin
                            hold_buf   <= wb.wb_dat_i;
                            hold_pc    <= req_adr;
                            bus_active <= 1'b0;
                            // A flush in the same cycle squashes the parked word too.
                            state      <= flush ? S_IDLE : S_HOLD;
                        end else begin
                            req_adr <= req_next;
                        end
                    end
                end
                S_DROP: begin
                    if (use_branch) begin
                        pc_reg <= target;
                    end
                    if (ack) begin
                        state      <= S_IDLE;
                        bus_active <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (use_branch) begin
                        pc_reg <= target;
                        state  <= S_IDLE;
                    end else if (flush || !stall) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus_active <= 1'b0;
                end
            endcase

            // IF/ID register: squash > hold > load > bubble.
            if (flush || use_branch) begin
                inst_out   <= NOP;
                inst_valid <= 1'b0;
            end else if (!stall) begin
                if (deliver_bus) begin
                    inst_out   <= wb.wb_dat_i;
                    pc_out     <= req_adr;
                    inst_valid <= 1'b1;
                end else if (deliver_hold) begin
                    inst_out   <= hold_buf;
                    pc_out     <= hold_pc;
                    inst_valid <= 1'b1;
                end else begin
                    inst_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count    <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if ((state == S_BUSY) && ack && !use_branch) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (use_branch) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, flush, use_branch;
    logic [31:0] branch_out;
    logic [31:0] inst_out, pc_out;
    logic        inst_valid;

    logic        reset2;
    logic [31:0] inst2, pc2;
    logic        valid2;

    int tests  = 0;
    int failed = 0;
    int wait_states = 0;
    int wcnt = 0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fc1, rc1, fc2, rc2;
`endif

    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    // Memory model: data = ~address, ack after wait_states cycles of strobe.
    assign bus.wb_ack_i  = bus.wb_stb_o && (wcnt == wait_states);
    assign bus.wb_dat_i  = ~bus.wb_adr_o;
    assign bus2.wb_ack_i = bus2.wb_stb_o;
    assign bus2.wb_dat_i = ~bus2.wb_adr_o;

    always @(posedge clk) begin
        if (!bus.wb_stb_o || bus.wb_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .use_branch(use_branch), .branch_out(branch_out), .wb(bus),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
`ifdef IF_PERF_CNT_EN
        , .fetch_count(fc1), .redirect_count(rc1)
`endif
    );

    if_fetch_unit #(.PC_ADDR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0), .flush(1'b0),
        .use_branch(1'b0), .branch_out(32'h0), .wb(bus2),
        .inst_out(inst2), .pc_out(pc2), .inst_valid(valid2)
`ifdef IF_PERF_CNT_EN
        , .fetch_count(fc2), .redirect_count(rc2)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; use_branch = 1'b0; branch_out = 32'h0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b1; flush = 1'b0; use_branch = 1'b1; branch_out = 32'h1234_5678;
        wait_states = 0;
        repeat (2) tick();
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
        tests++; if (inst_out !== 32'h0000_0013) begin failed++; $display("FAIL rst_inst got %h exp 00000013", inst_out); end
        tests++; if (pc_out !== 32'h8000_0000) begin failed++; $display("FAIL rst_pc got %h exp 80000000", pc_out); end
        tests++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin failed++; $display("FAIL rst_cyc got %b%b exp 00", bus.wb_cyc_o, bus.wb_stb_o); end
        tests++; if (bus.wb_adr_o !== 32'h8000_0000) begin failed++; $display("FAIL rst_adr got %h exp 80000000", bus.wb_adr_o); end
        tests++; if (bus.wb_we_o !== 1'b0 || bus.wb_sel_o !== 4'b1111) begin failed++; $display("FAIL rst_we_sel got %b %b exp 0 1111", bus.wb_we_o, bus.wb_sel_o); end
    endtask

    task automatic test_back_to_back();
        wait_states = 0;
        do_reset();
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0000) begin failed++; $display("FAIL b2b_req0 got %b %h exp 1 80000000", bus.wb_cyc_o, bus.wb_adr_o); end
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL b2b_valid1 got %b exp 0", inst_valid); end
        tick();
        tests++; if (bus.wb_adr_o !== 32'h8000_0004) begin failed++; $display("FAIL b2b_adr4 got %h exp 80000004", bus.wb_adr_o); end
        tests++; if (pc_out !== 32'h8000_0000 || inst_valid !== 1'b1) begin failed++; $display("FAIL b2b_pc0 got %h %b exp 80000000 1", pc_out, inst_valid); end
        tests++; if (inst_out !== 32'h7FFF_FFFF) begin failed++; $display("FAIL b2b_inst0 got %h exp 7fffffff", inst_out); end
        tick();
        tests++; if (bus.wb_adr_o !== 32'h8000_0008) begin failed++; $display("FAIL b2b_adr8 got %h exp 80000008", bus.wb_adr_o); end
        tests++; if (pc_out !== 32'h8000_0004 || inst_out !== 32'h7FFF_FFFB || inst_valid !== 1'b1) begin failed++; $display("FAIL b2b_pc4 got %h %h %b exp 80000004 7ffffffb 1", pc_out, inst_out, inst_valid); end
    endtask

    task automatic test_stall();
        wait_states = 0;
        do_reset();
        repeat (2) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.wb_cyc_o !== 1'b0 || pc_out !== 32'h8000_0000 || inst_valid !== 1'b1) begin failed++; $display("FAIL stall_hold%0d got cyc=%b pc=%h v=%b exp 0 80000000 1", i, bus.wb_cyc_o, pc_out, inst_valid); end
        end
        stall = 1'b0;
        tick();
        tests++; if (pc_out !== 32'h8000_0004 || inst_out !== 32'h7FFF_FFFB || inst_valid !== 1'b1) begin failed++; $display("FAIL stall_release got %h %h %b exp 80000004 7ffffffb 1", pc_out, inst_out, inst_valid); end
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0008 || inst_valid !== 1'b0) begin failed++; $display("FAIL stall_refetch got %b %h %b exp 1 80000008 0", bus.wb_cyc_o, bus.wb_adr_o, inst_valid); end
        tick();
        tests++; if (pc_out !== 32'h8000_0008 || inst_valid !== 1'b1) begin failed++; $display("FAIL stall_next got %h %b exp 80000008 1", pc_out, inst_valid); end
    endtask

    task automatic test_branch_drop();
        wait_states = 3;
        do_reset();
        repeat (9) tick();
        tests++; if (pc_out !== 32'h8000_0004 || bus.wb_adr_o !== 32'h8000_0008) begin failed++; $display("FAIL br_pre got %h %h exp 80000004 80000008", pc_out, bus.wb_adr_o); end
        use_branch = 1'b1; branch_out = 32'h8000_0103;
        tick();
        use_branch = 1'b0; branch_out = 32'h0;
        tests++; if (inst_out !== 32'h0000_0013 || inst_valid !== 1'b0) begin failed++; $display("FAIL br_squash got %h %b exp 00000013 0", inst_out, inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0008 || inst_valid !== 1'b0) begin failed++; $display("FAIL br_drop%0d got %b %h %b exp 1 80000008 0", i, bus.wb_cyc_o, bus.wb_adr_o, inst_valid); end
            tick();
        end
        tests++; if (bus.wb_cyc_o !== 1'b0 || inst_valid !== 1'b0) begin failed++; $display("FAIL br_idle got %b %b exp 0 0", bus.wb_cyc_o, inst_valid); end
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0100 || inst_valid !== 1'b0) begin failed++; $display("FAIL br_target got %b %h %b exp 1 80000100 0", bus.wb_cyc_o, bus.wb_adr_o, inst_valid); end
        repeat (4) tick();
        tests++; if (pc_out !== 32'h8000_0100 || inst_out !== 32'h7FFF_FEFF || inst_valid !== 1'b1) begin failed++; $display("FAIL br_deliver got %h %h %b exp 80000100 7ffffeff 1", pc_out, inst_out, inst_valid); end
    endtask

    task automatic test_flush_stall();
        wait_states = 0;
        do_reset();
        repeat (2) tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        tests++; if (inst_out !== 32'h0000_0013 || inst_valid !== 1'b0) begin failed++; $display("FAIL fl_squash got %h %b exp 00000013 0", inst_out, inst_valid); end
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0008 || inst_valid !== 1'b0) begin failed++; $display("FAIL fl_refetch got %b %h %b exp 1 80000008 0", bus.wb_cyc_o, bus.wb_adr_o, inst_valid); end
        tick();
        tests++; if (pc_out !== 32'h8000_0008 || inst_out !== 32'h7FFF_FFF7 || inst_valid !== 1'b1) begin failed++; $display("FAIL fl_next got %h %h %b exp 80000008 7ffffff7 1", pc_out, inst_out, inst_valid); end
    endtask

    task automatic test_reset_drop();
        wait_states = 3;
        do_reset();
        tick();
        use_branch = 1'b1; branch_out = 32'h8000_0200;
        tick();
        use_branch = 1'b0; branch_out = 32'h0;
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0000) begin failed++; $display("FAIL rd_drop got %b %h exp 1 80000000", bus.wb_cyc_o, bus.wb_adr_o); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_adr_o !== 32'h8000_0000) begin failed++; $display("FAIL rd_bus got %b %h exp 0 80000000", bus.wb_cyc_o, bus.wb_adr_o); end
        tests++; if (inst_out !== 32'h0000_0013 || pc_out !== 32'h8000_0000 || inst_valid !== 1'b0) begin failed++; $display("FAIL rd_ifid got %h %h %b exp 00000013 80000000 0", inst_out, pc_out, inst_valid); end
        reset = 1'b1;
        tick();
        tests++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h8000_0000 || inst_valid !== 1'b0) begin failed++; $display("FAIL rd_first got %b %h %b exp 1 80000000 0", bus.wb_cyc_o, bus.wb_adr_o, inst_valid); end
        repeat (3) tick();
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL rd_wait got %b exp 0", inst_valid); end
        tick();
        tests++; if (pc_out !== 32'h8000_0000 || inst_out !== 32'h7FFF_FFFF || inst_valid !== 1'b1) begin failed++; $display("FAIL rd_deliver got %h %h %b exp 80000000 7fffffff 1", pc_out, inst_out, inst_valid); end
    endtask

    task automatic test_wrap();
        reset2 = 1'b0;
        repeat (2) tick();
        reset2 = 1'b1;
        tick();
        tests++; if (bus2.wb_adr_o !== 32'hFFFF_FFF8) begin failed++; $display("FAIL wr_adr0 got %h exp fffffff8", bus2.wb_adr_o); end
        tick();
        tests++; if (pc2 !== 32'hFFFF_FFF8 || bus2.wb_adr_o !== 32'hFFFF_FFFC || valid2 !== 1'b1) begin failed++; $display("FAIL wr_1 got %h %h %b exp fffffff8 fffffffc 1", pc2, bus2.wb_adr_o, valid2); end
        tick();
        tests++; if (pc2 !== 32'hFFFF_FFFC || bus2.wb_adr_o !== 32'h0000_0000) begin failed++; $display("FAIL wr_2 got %h %h exp fffffffc 00000000", pc2, bus2.wb_adr_o); end
        tick();
        tests++; if (pc2 !== 32'h0000_0000 || inst2 !== 32'hFFFF_FFFF || valid2 !== 1'b1) begin failed++; $display("FAIL wr_3 got %h %h %b exp 00000000 ffffffff 1", pc2, inst2, valid2); end
    endtask

    initial begin
        reset = 1'b0; reset2 = 1'b0; stall = 1'b0; flush = 1'b0;
        use_branch = 1'b0; branch_out = 32'h0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_branch_drop();
        test_flush_stall();
        test_reset_drop();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RISC-V pipeline; the consuming end of the branch-resolution interface.
- Owns the PC register and takes redirect requests (use_branch/branch_out) and flush from the branch unit.
- Fetches instructions from instruction memory as a Wishbone-classic read master.
- Drives the IF/ID pipeline register (inst_out, pc_out, inst_valid), honouring the hazard-unit stall.

Parameters:
PC_ADDR  32'h8000_0000  reset/boot PC
ADDR_WIDTH  32  address width
DATA_WIDTH  32  instruction/bus data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
stall  in  1  hold IF/ID contents
flush  in  1  squash IF/ID contents
use_branch  in  1  redirect request, one-cycle pulse
branch_out  in  ADDR_WIDTH  redirect target
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_we_o  out  1  constant 0
wb_sel_o  out  4  constant 4'b1111
wb_adr_o  out  ADDR_WIDTH  request address (req_adr register)
wb_dat_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  read ack
inst_out  out  DATA_WIDTH  IF/ID instruction
pc_out  out  ADDR_WIDTH  IF/ID PC
inst_valid  out  1  IF/ID valid

Behaviour:
- Reset (reset==0 at posedge):
  - state=S_IDLE; pc_reg=PC_ADDR; req_adr=PC_ADDR.
  - inst_out=32'h0000_0013 (NOP); pc_out=PC_ADDR; inst_valid=0.
  - Reset overrides every other input, including mid-transaction; the pending ack is ignored.
- wb_cyc_o = wb_stb_o = (state==S_BUSY || state==S_DROP). Both are low in S_IDLE and S_HOLD.
- Redirect target: pc_reg <= {branch_out[ADDR_WIDTH-1:2],2'b00}. Bits [1:0] are always cleared.
- PC increment: +4, modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC wraps to 0.
- S_IDLE: req_adr<=pc_reg; go to S_BUSY. If use_branch is high, req_adr takes the aligned target directly.
- S_BUSY: req_adr is held stable until ack.
  - ack, no use_branch, no stall: inst_out<=wb_dat_i; pc_out<=req_adr; inst_valid<=1; pc_reg<=req_adr+4; req_adr<=req_adr+4. Stay in S_BUSY (back-to-back reads; one instruction per ack).
  - ack & stall: hold_buf<=wb_dat_i; hold_pc<=req_adr; pc_reg<=req_adr+4; go to S_HOLD.
  - ack & use_branch: discard data; pc_reg<=target; go to S_IDLE.
  - use_branch without ack: pc_reg<=target; go to S_DROP. wb_adr_o is unchanged (Wishbone stability).
- S_DROP: the outstanding request is kept.
  - On ack: data is discarded; go to S_IDLE.
  - A further use_branch overwrites pc_reg and the state stays S_DROP.
- S_HOLD: bus idle.
  - When stall falls: inst_out<=hold_buf; pc_out<=hold_pc; inst_valid<=1; go to S_IDLE.
  - use_branch in S_HOLD: drop the buffer; pc_reg<=target; go to S_IDLE.
- IF/ID update priority, applied every cycle:
  1. flush or use_branch: inst_out<=NOP; inst_valid<=0. Overrides stall and same-cycle ack data.
  2. stall: hold all three outputs.
  3. Delivered instruction (ack or S_HOLD release): load it.
  4. Otherwise: inst_valid<=0 (bubble). inst_out and pc_out are held.
- Latency: first instruction reaches IF/ID 2 cycles after reset release with zero-wait ack (S_IDLE, then S_BUSY+ack, then registered).
- No instruction is ever delivered twice or skipped. Every ack is consumed exactly once.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count (32): increments on each ack accepted into IF/ID or hold_buf.
  - redirect_count (32): increments on each cycle with use_branch=1.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset release, memory acks in the same cycle as stb → wb_adr_o sequence 8000_0000, 8000_0004, 8000_0008. IF/ID shows matching pc_out with inst_valid=1 from cycle 2.
- Stall held 3 cycles coinciding with the ack for 8000_0004 → IF/ID keeps 8000_0000, bus idle during S_HOLD. On release, pc_out=8000_0004, then the fetch of 8000_0008.
- use_branch pulse with target 8000_0103 while the 3-wait-state read of 8000_0008 is pending → wb_adr_o stays 8000_0008 until ack. That data is discarded, the next request is 8000_0100, and inst_valid=0 throughout.
- flush and stall both high with an ack in the same cycle → inst_out=0000_0013, inst_valid=0. The acked data is not delivered.
- PC_ADDR=32'hFFFF_FFF8 → fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset driven low during S_DROP → all outputs return to reset values next cycle. After release the first request is to PC_ADDR, and the stale ack is ignored.
